// File: rtl/data_ram_pkg.sv
// Shared constants for the data RAM and its memory-mapped I/O window.
// Holds the default I/O window base, the default RAM word-index width and
// the register offsets inside the 256-byte I/O window.
package data_ram_pkg;

  localparam logic [31:0] DATA_RAM_MMIO_BASE  = 32'hFFFF_FF00;
  localparam int          DATA_RAM_ADDR_WIDTH = 12;

  localparam logic [7:0] MMIO_LED   = 8'h00;
  localparam logic [7:0] MMIO_CYCLE = 8'h04;
  localparam logic [7:0] MMIO_HALT  = 8'h08;

endpackage

// File: rtl/data_ram_mmio_mmio_regs.sv
// mmio_regs: LED register, sticky halt flag, free-running cycle counter and
// their combinational read mux.
// Ports: clk/reset (async active-high); wr_en/offset/sel/wr_data = decoded
// write strobe, word-aligned offset, lanes 0-1 and low write data;
// rd_data = register selected by offset; led/halt/cycle = register state.
module mmio_regs
  import data_ram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  offset,
  input  logic [1:0]  sel,
  input  logic [15:0] wr_data,
  output logic [31:0] rd_data,
  output logic [15:0] led,
  output logic        halt,
  output logic [31:0] cycle
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led   <= '0;
      halt  <= 1'b0;
      cycle <= '0;
    end else begin
      // The edge that sets halt still sees halt=0, so it performs the final
      // increment; the count freezes from the following edge on.
      if (!halt) begin
        cycle <= cycle + 32'd1;
      end
      if (wr_en && offset == MMIO_LED) begin
        if (sel[0]) led[7:0]  <= wr_data[7:0];
        if (sel[1]) led[15:8] <= wr_data[15:8];
      end
      // Sticky: only a 1 in bit 0 has any effect; cleared solely by reset.
      if (wr_en && offset == MMIO_HALT && sel[0] && wr_data[0]) begin
        halt <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      MMIO_LED:   rd_data = {16'h0000, led};
      MMIO_CYCLE: rd_data = cycle;
      MMIO_HALT:  rd_data = {31'h0, halt};
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_mmio.sv
// data_ram_mmio: word-addressed data RAM with byte-lane writes plus an I/O
// window (LED, cycle counter, halt). Reads are combinational, writes land on
// the rising edge. Ports: clk, reset (async active-high), ce/we/addr/sel/
// data_i from the MEM stage, data_o read data, led_o/halt_o/cycle_o status.
module data_ram_mmio
  import data_ram_pkg::*;
#(
  parameter int          ADDR_WIDTH = DATA_RAM_ADDR_WIDTH,
  parameter logic [31:0] MMIO_BASE  = DATA_RAM_MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [15:0] led_o,
  output logic        halt_o,
  output logic [31:0] cycle_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  en;
  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           ram_word;
  logic [31:0]           mmio_rd;
  logic                  unused_addr_bits;

  assign en      = |ce;
  assign is_mmio = (addr[31:8] == MMIO_BASE[31:8]);
  // Address bits above the index are not decoded for RAM, so they alias.
  assign idx     = addr[ADDR_WIDTH+1:2];

  // Byte offset within a word plays no part in any decode.
  assign unused_addr_bits = ^addr[1:0];

  // One array per byte lane so each lane has its own write enable. The RAM
  // has no reset: its contents survive a reset pulse.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (en && we && !is_mmio && sel[i]) begin
        mem[idx] <= data_i[8*i +: 8];
      end
    end

    assign ram_word[8*i +: 8] = mem[idx];
  end

  mmio_regs u_mmio_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (en && we && is_mmio),
    .offset  ({addr[7:2], 2'b00}),
    .sel     (sel[1:0]),
    .wr_data (data_i[15:0]),
    .rd_data (mmio_rd),
    .led     (led_o),
    .halt    (halt_o),
    .cycle   (cycle_o)
  );

  // Full word is returned regardless of sel; the MEM stage extracts lanes.
  always_comb begin
    data_o = '0;
    if (en && !we) begin
      data_o = is_mmio ? mmio_rd : ram_word;
    end
  end

endmodule

// File: tb/tb_data_ram_mmio.sv
module tb_data_ram_mmio;

  logic        clk;
  logic        reset;
  logic [3:0]  ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [15:0] led_o;
  logic        halt_o;
  logic [31:0] cycle_o;

  data_ram_mmio dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .we      (we),
    .addr    (addr),
    .sel     (sel),
    .data_i  (data_i),
    .data_o  (data_o),
    .led_o   (led_o),
    .halt_o  (halt_o),
    .cycle_o (cycle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [31:0] mask;
    logic [15:0] led;
    logic        halt;
    logic [31:0] cycle;
  } exp_t;

  exp_t sb[$];

  // Reference model: whole words per index, plus which bytes are known.
  logic [31:0] m_mem   [int];
  logic [3:0]  m_known [int];
  logic [15:0] m_led;
  logic        m_halt;
  logic [31:0] m_cycle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each cycle with an issued operation, compare all outputs.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.mask != 32'h0) chk({e.name, ".data_o"}, data_o & e.mask, e.data & e.mask);
      chk({e.name, ".led_o"},   {16'h0, led_o},  {16'h0, e.led});
      chk({e.name, ".halt_o"},  {31'h0, halt_o}, {31'h0, e.halt});
      chk({e.name, ".cycle_o"}, cycle_o,         e.cycle);
    end
  end

  // Drive one cycle's access, predict outputs, then advance the model.
  task automatic op(input string nm, input logic [3:0] c, input logic w,
                    input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                    input bit use_const = 1'b0, input logic [31:0] cval = 32'h0);
    exp_t        e;
    int          idx;
    bit          mm;
    logic [7:0]  off;
    logic        halt_pre;
    logic [31:0] wd;
    logic [3:0]  kn;
    ce = c; we = w; addr = a; sel = s; data_i = d;
    mm  = (a >= 32'hFFFF_FF00);
    off = a[7:0] & 8'hFC;
    idx = int'((a / 4) % 4096);
    e.name = nm; e.led = m_led; e.halt = m_halt; e.cycle = m_cycle;
    e.data = 32'h0; e.mask = 32'hFFFF_FFFF;
    if (c != 4'h0 && !w) begin
      if (mm) begin
        if (off == 8'h00)      e.data = {16'h0, m_led};
        else if (off == 8'h04) e.data = m_cycle;
        else if (off == 8'h08) e.data = {31'h0, m_halt};
      end else if (m_known.exists(idx)) begin
        e.data = m_mem[idx];
        kn = m_known[idx];
        for (int i = 0; i < 4; i++) e.mask[8*i +: 8] = kn[i] ? 8'hFF : 8'h00;
      end else begin
        e.mask = 32'h0;
      end
    end
    if (use_const) begin
      e.data = cval;
      e.mask = 32'hFFFF_FFFF;
    end
    sb.push_back(e);
    @(posedge clk);
    halt_pre = m_halt;
    if (c != 4'h0 && w) begin
      if (mm) begin
        if (off == 8'h00) begin
          if (s[0]) m_led[7:0]  = d[7:0];
          if (s[1]) m_led[15:8] = d[15:8];
        end else if (off == 8'h08 && s[0] && d[0]) begin
          m_halt = 1'b1;
        end
      end else begin
        wd = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        kn = m_known.exists(idx) ? m_known[idx] : 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (s[i]) begin
            wd[8*i +: 8] = d[8*i +: 8];
            kn[i] = 1'b1;
          end
        end
        m_mem[idx] = wd;
        m_known[idx] = kn;
      end
    end
    if (!halt_pre) m_cycle = m_cycle + 32'd1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] bases [3];
  int          guard;

  initial begin
    logic [3:0]  rc;
    logic        rw;
    logic [31:0] ra;
    bases[0] = 32'h0000_0000; bases[1] = 32'h0000_4000; bases[2] = 32'h8000_0000;
    reset = 1'b1; ce = 4'h0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0;
    m_led = 16'h0; m_halt = 1'b0; m_cycle = 32'h0;

    // Reset state
    #3;
    chk("reset.led_o",   {16'h0, led_o},  32'h0);
    chk("reset.halt_o",  {31'h0, halt_o}, 32'h0);
    chk("reset.cycle_o", cycle_o,         32'h0);
    chk("reset.data_o",  data_o,          32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cycle counter: the 10th cycle after release reads 9
    for (int i = 0; i < 9; i++) op("idle", 4'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    op("cycle10", 4'hF, 1'b0, 32'hFFFF_FF04, 4'hF, 32'h0, 1'b1, 32'd9);

    // Word write/read, byte lanes, aliasing, disable
    op("wr_word",  4'hF, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    op("rd_word",  4'hF, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    op("rd_other", 4'hF, 1'b0, 32'h0000_0014, 4'hF, 32'h0);
    op("rd_word2", 4'h1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);
    op("wr_lane0", 4'hF, 1'b1, 32'h0000_0010, 4'b0001, 32'h0000_0055);
    op("wr_lane3", 4'hF, 1'b1, 32'h0000_0010, 4'b1000, 32'hAA00_0000);
    op("rd_lanes", 4'b0100, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1, 32'hAAAD_BE55);
    op("wr_alias", 4'hF, 1'b1, 32'h0000_4010, 4'hF, 32'h1234_5678);
    op("rd_alias", 4'hF, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'h1234_5678);
    op("wr_ce0",   4'h0, 1'b1, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF);
    op("rd_after_ce0", 4'hF, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'h1234_5678);
    op("rd_ce0",   4'h0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'h0);

    // LED and read-only CYCLE
    op("wr_led",   4'hF, 1'b1, 32'hFFFF_FF00, 4'hF, 32'hFFFF_A5C3);
    op("rd_led",   4'hF, 1'b0, 32'hFFFF_FF00, 4'hF, 32'h0, 1'b1, 32'h0000_A5C3);
    op("wr_cycle", 4'hF, 1'b1, 32'hFFFF_FF04, 4'hF, 32'h0);
    op("rd_cycle", 4'hF, 1'b0, 32'hFFFF_FF04, 4'hF, 32'h0);
    op("rd_unmapped", 4'hF, 1'b0, 32'hFFFF_FF0C, 4'hF, 32'h0, 1'b1, 32'h0);

    // Run up to 499 so the halt edge makes the last increment to 500
    guard = 0;
    while (m_cycle != 32'd499 && guard < 2000) begin
      op("idle", 4'h0, 1'b0, 32'h0, 4'h0, 32'h0);
      guard++;
    end
    chk("reach_499", m_cycle, 32'd499);
    op("wr_halt", 4'hF, 1'b1, 32'hFFFF_FF08, 4'h1, 32'h0000_0001);
    for (int i = 0; i < 20; i++)
      op("rd_frozen", 4'hF, 1'b0, 32'hFFFF_FF04, 4'hF, 32'h0, 1'b1, 32'd500);
    op("wr_halt0", 4'hF, 1'b1, 32'hFFFF_FF08, 4'hF, 32'h0);
    op("rd_halt",  4'hF, 1'b0, 32'hFFFF_FF08, 4'hF, 32'h0, 1'b1, 32'h1);

    // Asynchronous reset between edges
    ce = 4'h0;
    #1 reset = 1'b1;
    #1;
    chk("arst.led_o",   {16'h0, led_o},  32'h0);
    chk("arst.halt_o",  {31'h0, halt_o}, 32'h0);
    chk("arst.cycle_o", cycle_o,         32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_led = 16'h0; m_halt = 1'b0; m_cycle = 32'h0;
    op("rd_after_rst", 4'hF, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'h1234_5678);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rc = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7)
        ra = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      else
        ra = 32'hFFFF_FF00 + 32'($urandom_range(0, 4)) * 4;
      op("rand", rc, rw, ra, 4'($urandom_range(0, 15)), $urandom);
    end

    ce = 4'h0;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram_mmio.md
# data_ram_mmio

Word-addressed data memory with byte-lane writes, plus a small memory-mapped I/O window holding an LED register, a free-running cycle counter and a sticky halt flag. It sits directly downstream of the core's MEM stage. It consumes `ram_addr_o`, `ram_data_o`, `ram_we_o`, `ram_sel_o` and `ram_ce_o`, and returns `ram_data_i` in the same cycle, because the MEM stage samples it combinationally.

## Interface
- `ADDR_WIDTH`, default 12: word-index width; RAM holds 2^ADDR_WIDTH 32-bit words (16 KiB).
- `MMIO_BASE`, default 32'hFFFF_FF00: base of the 256-byte I/O window.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `ce` in 4: chip enable from the MEM stage; the access is enabled when any bit is 1.
- `we` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `sel` in 4: byte-lane enables; `sel[i]` selects `data_i[8i+7:8i]`.
- `data_i` in 32: write data.
- `data_o` out 32: read data, combinational.
- `led_o` out 16: LED register.
- `halt_o` out 1: sticky halt flag.
- `cycle_o` out 32: current cycle-counter value, for debug.

## Operation
- An access is enabled when `ce != 4'b0000`. When it is not enabled:
  - `data_o` = 0.
  - No state changes, apart from the cycle counter.
- Address decode:
  - MMIO when `addr[31:8] == MMIO_BASE[31:8]`; otherwise RAM.
  - RAM index is `addr[ADDR_WIDTH+1:2]`; higher address bits alias.
- RAM write:
  - Occurs at the rising edge when enabled, `we=1` and the address decodes to RAM.
  - Each lane i with `sel[i]=1` is written; other lanes keep their old contents.
  - `sel=0` writes nothing.
- RAM read: when enabled and `we=0`, `data_o` = the full stored word, independent of `sel`. Lane extraction belongs to the MEM stage.
- While `we=1`, `data_o` = 0.
- RAM contents are not reset; they are undefined until written.
- MMIO registers (offset = `addr[7:0]`):
  - 0x00 LED: R/W. Lanes 0 and 1 are writable; bits 31:16 read as 0.
  - 0x04 CYCLE: read-only. Writes are ignored.
  - 0x08 HALT:
    - A write with `sel[0]=1` and `data_i[0]=1` sets `halt`.
    - Writing 0 has no effect; the flag clears only on reset.
    - Reads return `{31'b0, halt}`.
  - All other offsets read 0; writes to them are ignored.
- Cycle counter:
  - Increments by 1 each clock while `halt=0` and freezes while `halt=1`.
  - Wraps from 32'hFFFF_FFFF to 0.
  - A CYCLE read returns the pre-edge value of the current cycle.

## Timing
- Read latency is 0 cycles: `data_o` follows `addr`, `ce` and `we` combinationally, with no clock in the path.
- Write-to-read latency is 1: a word written at edge N is returned by a read in cycle N+1.
- `led_o` and `halt_o` change immediately after the edge that performs the write.
- The HALT write edge also performs the last increment of the counter: the counter holds its value from the edge after that.
- Reset, asserted at any time, takes effect immediately and asynchronously:
  - `led_o` = 0, `halt_o` = 0, `cycle_o` = 0.
  - `data_o` is combinational from its inputs, and is therefore 0 while `ce` = 0.
  - RAM contents are untouched.
- Reset asserted mid-write: the write may or may not land in RAM. MMIO registers are guaranteed to hold their reset values.
- There are no handshake or wait states; every access completes in one cycle.

## Structure
- Shared package `data_ram_pkg`:
  - `MMIO_BASE` default.
  - Offsets `MMIO_LED=8'h00`, `MMIO_CYCLE=8'h04`, `MMIO_HALT=8'h08`.
  - `DATA_RAM_ADDR_WIDTH` default.
- Top `data_ram_mmio` holds:
  - the decode;
  - the RAM array as four 8-bit lane arrays, so each lane is written independently;
  - the read mux between the RAM and MMIO.
- One sub-module, `mmio_regs`, holds the LED, HALT and cycle-counter registers and their read mux.

## Test plan
- Word write then read: write 32'hDEAD_BEEF to 0x0000_0010 with `sel=4'hF`, then read 0x10 → 32'hDEAD_BEEF the next cycle; read 0x14 → no change to the stored word.
- Byte lanes: after the above, write 32'h0000_0055 with `sel=4'b0001`, then 32'hAA00_0000 with `sel=4'b1000`; read → 32'hAAAD_BE55.
- Aliasing and disable:
  - Write 32'h1234_5678 at 0x0000_4010 (ADDR_WIDTH=12), then read 0x10 → 32'h1234_5678.
  - A write with `ce=0` changes nothing.
  - A read with `ce=0` returns 0.
- LED: write 32'hFFFF_A5C3 to 0xFFFF_FF00 with `sel=4'hF` → `led_o`=16'hA5C3 after the edge; read → 32'h0000_A5C3.
- Cycle and halt:
  - After reset release, read CYCLE at the 10th cycle → 9; `cycle_o` tracks the count.
  - Write 1 to HALT → `halt_o`=1; CYCLE holds constant for the next 20 cycles.
  - Writing 0 to HALT → `halt_o` stays 1.
- Async reset: with `led_o`=16'hA5C3, `halt_o`=1 and CYCLE=500, assert `reset` between edges → all three go to 0 immediately. RAM word 0x10 still holds its prior value after reset is released.
